iir_coef_loader: RTL and testbench
==================================

# iir_coef_loader

Coefficient configuration controller for the cascaded `i16_biquad` second-order-section chain. It accepts a serial stream of Q2.14 coefficient words over a valid/ready handshake and collects them in a shadow bank. On a complete, well-formed frame it applies all sections atomically and pulses a filter-state flush. It sits between the host/config interface and the biquad cascade, replacing the hard-wired coefficient constants.

## Interface
Parameters:
- `N_SOS`, 3, number of biquad sections driven.
- `W`, 16, coefficient word width; signed Q2.14, so 16384 = 1.0.
- `FLUSH_CYC`, 2, number of cycles `filt_rst` is held after an apply (≥1).

Ports:
- `CLK`  in  1  system clock; all logic on the rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `cfg_valid`  in  1  `cfg_data` valid.
- `cfg_ready`  out  1  loader can accept a word.
- `cfg_data`  in  W  signed coefficient word.
- `cfg_last`  in  1  marks the final word of the frame.
- `cfg_abort`  in  1  discard the frame in progress.
- `b0_bus`, `b1_bus`, `b2_bus`, `a1_bus`, `a2_bus`  out  N_SOS*W  active coefficients; section k occupies bits [k*W+W-1 : k*W].
- `filt_rst`  out  1  active-high reset to the biquad cascade, OR'd with `RST` at the top level.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle pulse when the apply completes.
- `err`  out  1  one-cycle pulse on a framing error.

## Operation
- Frame: exactly 5*N_SOS words. Order per section is b0, b1, b2, a1, a2, starting at section 0 and ascending.
- Counters: `word_idx` (0..4) and `sec_idx` (0..N_SOS-1). An accepted word writes `shadow[sec_idx][word_idx]`, then advances; `word_idx` wraps 4→0 and increments `sec_idx`.
- Accept condition: `cfg_valid & cfg_ready`.
- States:
  - IDLE: `cfg_ready`=1. An accepted word goes to LOAD with index 0 written; counters reset on entry to IDLE.
  - LOAD: `cfg_ready`=1.
    - Accepted word with `cfg_last`=1 at final index (sec N_SOS-1, word 4) → APPLY.
    - `cfg_last`=1 at any other index, or final index without `cfg_last` → `err` pulse, go to IDLE. Shadow is discarded; active is unchanged.
  - APPLY: `cfg_ready`=0. Next edge: active ← shadow for all sections in one cycle, `filt_rst`←1, go to FLUSH.
  - FLUSH: `cfg_ready`=0, `filt_rst`=1 for FLUSH_CYC cycles. Then `filt_rst`←0, `done` pulse, go to IDLE.
- `cfg_abort` in IDLE/LOAD → IDLE next edge, shadow discarded, no `err`. Abort beats a simultaneous accepted word. Abort is ignored in APPLY/FLUSH.
- An N_SOS=1 frame with `cfg_last` on the first word of a 5-word frame is a framing error, as is any early `cfg_last`.
- Shadow contents are only consumed at APPLY. Active coefficients never change outside APPLY.
- No arithmetic is performed on coefficients; they are stored bit-exact.

## Timing
- Reset values:
  - active and shadow b0 = 16384 and b1/b2/a1/a2 = 0 for every section (unity passthrough).
  - `filt_rst`=0, `done`=0, `err`=0, `busy`=0.
  - state IDLE; `cfg_ready`=1 in the first cycle with RST low.
- All outputs are registered except `cfg_ready` and `busy`, which decode the state register.
- Final word accepted at edge E:
  - APPLY during cycle E..E+1.
  - Active buses and `filt_rst`=1 visible after E+1.
  - `filt_rst` falls and `done`=1 after E+1+FLUSH_CYC.
  - `cfg_ready`=1 in that same cycle.
- `err` is asserted for the single cycle after the offending edge. `cfg_ready` stays 1 throughout.
- Gaps in `cfg_valid` are allowed indefinitely in LOAD; there is no timeout.
- RST mid-frame or mid-FLUSH: everything returns to reset values at that edge, including active coefficients going to passthrough.

## Test plan
- Reset check: after RST, every section's b0 reads 16384 and the other buses read 0. `cfg_ready`=1, `busy`=0 → passes an impulse of 16384 unchanged through the cascade.
- Full load, N_SOS=3:
  - Stimulus: 15 words (98,51,98,7845,0 / 16384,16384,0,17589,-5811 / 16384,-6928,16384,22801,-11728), `cfg_last` on word 15, with random `cfg_valid` gaps.
  - Required: buses hold exactly these values one edge after the last accept; `filt_rst` high 2 cycles; `done` 1 cycle.
- Early `cfg_last` on word 7 → `err` pulse. Active unchanged, state IDLE; a following correct frame loads cleanly from index 0.
- Missing `cfg_last` on word 15 → `err` pulse, active unchanged.
- `cfg_abort` asserted together with word 4 → no write committed, IDLE. Next frame starts at sec 0, word 0.
- Words offered during APPLY/FLUSH see `cfg_ready`=0 and are not consumed. RST asserted during FLUSH → `filt_rst`=0 and buses at passthrough on the next edge.

Source files
------------

// File: rtl/iir_coef_loader_if.sv
// Config and coefficient bundle between the host-side driver and the loader.
// Carries the word handshake plus the active coefficient buses and status strobes.
// The loader uses the slave view; the host/bench uses the master view.
interface iir_coef_loader_if #(
    parameter int N_SOS = 3,
    parameter int W     = 16
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [W-1:0]       cfg_data;
    logic               cfg_last;
    logic               cfg_abort;
    logic [N_SOS*W-1:0] b0_bus;
    logic [N_SOS*W-1:0] b1_bus;
    logic [N_SOS*W-1:0] b2_bus;
    logic [N_SOS*W-1:0] a1_bus;
    logic [N_SOS*W-1:0] a2_bus;
    logic               filt_rst;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output cfg_valid, cfg_data, cfg_last, cfg_abort,
        input  cfg_ready, b0_bus, b1_bus, b2_bus, a1_bus, a2_bus,
        input  filt_rst, busy, done, err
    );

    modport slave (
        input  cfg_valid, cfg_data, cfg_last, cfg_abort,
        output cfg_ready, b0_bus, b1_bus, b2_bus, a1_bus, a2_bus,
        output filt_rst, busy, done, err
    );
endinterface

// File: rtl/iir_coef_loader.sv
// Collects a 5*N_SOS word Q2.14 coefficient frame into a shadow bank and applies it atomically.
// Active buses update one edge after the final accept; filt_rst then holds FLUSH_CYC cycles.
// cfg_ready is high in IDLE/LOAD and low during APPLY/FLUSH; words offered then wait.
module iir_coef_loader #(
    parameter int N_SOS     = 3,
    parameter int W         = 16,
    parameter int FLUSH_CYC = 2
) (
    input  logic CLK,
    input  logic RST,
    iir_coef_loader_if.slave cfg
);
    localparam int SEC_W = (N_SOS > 1) ? $clog2(N_SOS) : 1;
    localparam int CNT_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [W-1:0] UNITY = W'(1 << (W - 2));

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_APPLY = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    logic [1:0]       state;
    logic [2:0]       word_idx;
    logic [SEC_W-1:0] sec_idx;
    logic [CNT_W-1:0] flush_cnt;
    logic             filt_rst_r;
    logic             done_r;
    logic             err_r;

    // Per section: index 0..4 = b0, b1, b2, a1, a2.
    logic [W-1:0] shadow [N_SOS][5];
    logic [W-1:0] active [N_SOS][5];

    logic accept;
    logic at_final;

    assign cfg.cfg_ready = (state == S_IDLE) || (state == S_LOAD);
    assign cfg.busy      = (state != S_IDLE);
    assign accept        = cfg.cfg_valid & cfg.cfg_ready;
    assign at_final      = (sec_idx == SEC_W'(N_SOS - 1)) && (word_idx == 3'd4);

    // Frame sequencing, shadow capture, atomic apply and flush timing.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_IDLE;
            word_idx   <= '0;
            sec_idx    <= '0;
            flush_cnt  <= '0;
            filt_rst_r <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            for (int k = 0; k < N_SOS; k++) begin
                for (int c = 0; c < 5; c++) begin
                    shadow[k][c] <= (c == 0) ? UNITY : '0;
                    active[k][c] <= (c == 0) ? UNITY : '0;
                end
            end
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state)
                S_IDLE, S_LOAD: begin
                    if (cfg.cfg_abort) begin
                        // Abort wins over a word offered in the same cycle.
                        state    <= S_IDLE;
                        word_idx <= '0;
                        sec_idx  <= '0;
                    end else if (accept) begin
                        shadow[sec_idx][word_idx] <= cfg.cfg_data;
                        if (at_final && cfg.cfg_last) begin
                            state    <= S_APPLY;
                            word_idx <= '0;
                            sec_idx  <= '0;
                        end else if (at_final || cfg.cfg_last) begin
                            // Misplaced or missing last: drop the frame, active untouched.
                            err_r    <= 1'b1;
                            state    <= S_IDLE;
                            word_idx <= '0;
                            sec_idx  <= '0;
                        end else begin
                            state <= S_LOAD;
                            if (word_idx == 3'd4) begin
                                word_idx <= '0;
                                sec_idx  <= sec_idx + SEC_W'(1);
                            end else begin
                                word_idx <= word_idx + 3'd1;
                            end
                        end
                    end
                end
                S_APPLY: begin
                    for (int k = 0; k < N_SOS; k++) begin
                        for (int c = 0; c < 5; c++) begin
                            active[k][c] <= shadow[k][c];
                        end
                    end
                    filt_rst_r <= 1'b1;
                    flush_cnt  <= '0;
                    state      <= S_FLUSH;
                end
                S_FLUSH: begin
                    if (flush_cnt == CNT_W'(FLUSH_CYC - 1)) begin
                        filt_rst_r <= 1'b0;
                        done_r     <= 1'b1;
                        state      <= S_IDLE;
                    end else begin
                        flush_cnt <= flush_cnt + CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    logic [N_SOS*W-1:0] b0_v, b1_v, b2_v, a1_v, a2_v;

    // Flatten the active bank onto the per-coefficient buses, section k at [k*W +: W].
    always_comb begin
        b0_v = '0;
        b1_v = '0;
        b2_v = '0;
        a1_v = '0;
        a2_v = '0;
        for (int k = 0; k < N_SOS; k++) begin
            b0_v[k*W +: W] = active[k][0];
            b1_v[k*W +: W] = active[k][1];
            b2_v[k*W +: W] = active[k][2];
            a1_v[k*W +: W] = active[k][3];
            a2_v[k*W +: W] = active[k][4];
        end
    end

    assign cfg.b0_bus   = b0_v;
    assign cfg.b1_bus   = b1_v;
    assign cfg.b2_bus   = b2_v;
    assign cfg.a1_bus   = a1_v;
    assign cfg.a2_bus   = a2_v;
    assign cfg.filt_rst = filt_rst_r;
    assign cfg.done     = done_r;
    assign cfg.err      = err_r;
endmodule

// File: tb/tb_iir_coef_loader.sv
// Scoreboard bench for iir_coef_loader: random-gapped frames, error/abort cases, reset in flush.
// Expected apply/err events are queued by a frame-level model; a negedge monitor checks them.
// Words offered while the loader is busy are held until cfg_ready returns.
module tb_iir_coef_loader;
    localparam int N  = 3;
    localparam int W  = 16;
    localparam int FC = 2;
    localparam int NW = 5 * N;

    typedef logic [NW*W-1:0] frame_t;
    typedef struct {
        bit     is_apply;
        frame_t fr;
        int     e;
    } exp_t;
    typedef struct {
        logic [W-1:0] d;
        bit           last;
        bit           ab;
    } tx_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    iir_coef_loader_if #(.N_SOS(N), .W(W)) bus ();

    iir_coef_loader #(.N_SOS(N), .W(W), .FLUSH_CYC(FC)) dut (
        .CLK (clk),
        .RST (rst),
        .cfg (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    exp_t         expq[$];
    logic [W-1:0] fq[$];
    tx_t          txq[$];
    frame_t       model_active;
    frame_t       pass_fr;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_fr(input string nm, input frame_t act, input frame_t exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Word i of a frame is section i/5, coefficient i%5 (b0,b1,b2,a1,a2).
    function automatic frame_t read_active();
        frame_t f;
        f = '0;
        for (int k = 0; k < N; k++) begin
            f[(k*5+0)*W +: W] = bus.b0_bus[k*W +: W];
            f[(k*5+1)*W +: W] = bus.b1_bus[k*W +: W];
            f[(k*5+2)*W +: W] = bus.b2_bus[k*W +: W];
            f[(k*5+3)*W +: W] = bus.a1_bus[k*W +: W];
            f[(k*5+4)*W +: W] = bus.a2_bus[k*W +: W];
        end
        return f;
    endfunction

    // Frame-level reference: a frame ends on last or on its 5*N-th word;
    // only a 5*N word frame closed by last is applied, anything else is an error.
    task automatic model_word(input logic [W-1:0] d, input bit last, input int e);
        exp_t x;
        fq.push_back(d);
        if (fq.size() == NW || last) begin
            x.is_apply = (fq.size() == NW) && last;
            x.fr = '0;
            for (int i = 0; i < fq.size(); i++) x.fr[i*W +: W] = fq[i];
            x.e = e;
            expq.push_back(x);
            fq.delete();
        end
    endtask

    task automatic offer(input tx_t t, input bit gap, output int waits);
        waits = 0;
        if (gap) repeat ($urandom_range(0, 2)) @(negedge clk);
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = t.d;
        bus.cfg_last  = t.last;
        bus.cfg_abort = t.ab;
        while (!bus.cfg_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (!bus.cfg_ready) chk("offer_ready_timeout", bus.cfg_ready, 1);
        // The word (or abort) takes effect on the coming edge, which will be cycle cyc+1.
        if (t.ab) fq.delete();
        else model_word(t.d, t.last, cyc + 1);
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        bus.cfg_last  = 1'b0;
        bus.cfg_abort = 1'b0;
    endtask

    task automatic run_tx(input bit nogap_first, output int first_wait);
        int w;
        bit first;
        tx_t t;
        first = 1'b1;
        first_wait = 0;
        while (txq.size() != 0) begin
            t = txq.pop_front();
            offer(t, !(first && nogap_first), w);
            if (first) first_wait = w;
            first = 1'b0;
        end
    endtask

    task automatic add_frame(input int n, input int last_at);
        tx_t t;
        for (int i = 1; i <= n; i++) begin
            t.d    = W'($urandom);
            t.last = (i == last_at);
            t.ab   = 1'b0;
            txq.push_back(t);
        end
    endtask

    task automatic wait_drain();
        int b;
        b = 0;
        while ((expq.size() != 0 || bus.busy) && b < 200) begin
            @(negedge clk);
            b++;
        end
        @(negedge clk);
        chk("drain_pending_events", expq.size(), 0);
    endtask

    // Scoreboard monitor: pops one expected event per err pulse or filt_rst rise.
    exp_t mx;
    bit   prev_f = 1'b0;
    bit   prev_err = 1'b0;
    bit   prev_done = 1'b0;
    int   run_len = 0;
    int   apply_cyc = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.err) begin
                chk("err_single_cycle", prev_err, 0);
                if (expq.size() == 0) chk("err_unexpected", expq.size(), 1);
                else begin
                    mx = expq.pop_front();
                    chk("err_kind_is_apply", mx.is_apply, 0);
                    chk("err_cycle", cyc, mx.e);
                    chk_fr("err_active_unchanged", read_active(), model_active);
                    chk("err_ready_high", bus.cfg_ready, 1);
                end
            end
            if (bus.filt_rst && !prev_f) begin
                run_len = 0;
                if (expq.size() == 0) chk("apply_unexpected", expq.size(), 1);
                else begin
                    mx = expq.pop_front();
                    chk("apply_kind_is_apply", mx.is_apply, 1);
                    chk("apply_cycle", cyc, mx.e + 1);
                    chk_fr("apply_buses", read_active(), mx.fr);
                    model_active = mx.fr;
                    apply_cyc = cyc;
                end
            end
            if (bus.filt_rst) run_len++;
            if (bus.done) begin
                chk("done_single_cycle", prev_done, 0);
                chk("flush_length", run_len, FC);
                chk("done_cycle", cyc, apply_cyc + FC);
                chk("done_filt_rst_low", bus.filt_rst, 0);
                chk("done_ready_high", bus.cfg_ready, 1);
                run_len = 0;
            end
            prev_f    = bus.filt_rst;
            prev_err  = bus.err;
            prev_done = bus.done;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int spec_words[NW] = '{98, 51, 98, 7845, 0,
                           16384, 16384, 0, 17589, -5811,
                           16384, -6928, 16384, 22801, -11728};

    initial begin
        int  w;
        int  b;
        tx_t t;

        bus.cfg_valid = 1'b0;
        bus.cfg_data  = '0;
        bus.cfg_last  = 1'b0;
        bus.cfg_abort = 1'b0;
        pass_fr = '0;
        for (int k = 0; k < N; k++) pass_fr[(k*5)*W +: W] = 16'd16384;
        model_active = pass_fr;

        // Reset state.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_cfg_ready", bus.cfg_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_filt_rst", bus.filt_rst, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk_fr("rst_passthrough", read_active(), pass_fr);
        mon_en = 1'b1;

        // Reference frame with random valid gaps.
        for (int i = 0; i < NW; i++) begin
            t.d = W'(spec_words[i]);
            t.last = (i == NW - 1);
            t.ab = 1'b0;
            txq.push_back(t);
        end
        run_tx(1'b0, w);

        // Next word offered immediately: held through APPLY plus FLUSH_CYC cycles.
        // That frame carries last on word 7.
        add_frame(7, 7);
        run_tx(1'b1, w);
        chk("ready_low_during_apply_flush", w, 1 + FC);
        wait_drain();

        // Clean frame right after the error.
        add_frame(NW, NW);
        run_tx(1'b0, w);
        wait_drain();

        // Missing last on the final word.
        add_frame(NW, 0);
        run_tx(1'b0, w);
        wait_drain();

        // Abort together with word 4, then a full frame from index 0.
        add_frame(3, 0);
        t.d = W'($urandom);
        t.last = 1'b0;
        t.ab = 1'b1;
        txq.push_back(t);
        add_frame(NW, NW);
        run_tx(1'b0, w);
        wait_drain();

        // Abort with no word mid-frame, then a full frame.
        add_frame(8, 0);
        run_tx(1'b0, w);
        bus.cfg_abort = 1'b1;
        fq.delete();
        @(negedge clk);
        bus.cfg_abort = 1'b0;
        add_frame(NW, NW);
        run_tx(1'b0, w);
        wait_drain();

        // Random mix of good, early-last and missing-last frames.
        for (int it = 0; it < 6; it++) begin
            case ($urandom_range(0, 2))
                0: add_frame(NW, NW);
                1: begin
                    b = $urandom_range(1, NW - 1);
                    add_frame(b, b);
                end
                default: add_frame(NW, 0);
            endcase
            run_tx(1'b0, w);
        end
        wait_drain();

        // Reset during FLUSH returns everything to passthrough.
        add_frame(NW, NW);
        run_tx(1'b0, w);
        b = 0;
        while (!bus.filt_rst && b < 20) begin
            @(negedge clk);
            b++;
        end
        chk("flush_seen_before_reset", bus.filt_rst, 1);
        #1;
        mon_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_in_flush_filt_rst", bus.filt_rst, 0);
        chk("rst_in_flush_done", bus.done, 0);
        chk("rst_in_flush_busy", bus.busy, 0);
        chk_fr("rst_in_flush_passthrough", read_active(), pass_fr);
        rst = 1'b0;
        model_active = pass_fr;
        fq.delete();
        expq.delete();
        prev_f = 1'b0;
        prev_err = 1'b0;
        prev_done = 1'b0;
        run_len = 0;
        @(negedge clk);
        mon_en = 1'b1;

        // Reset mid-frame, then a clean frame from index 0.
        add_frame(6, 0);
        run_tx(1'b0, w);
        mon_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        fq.delete();
        @(negedge clk);
        mon_en = 1'b1;
        add_frame(NW, NW);
        run_tx(1'b0, w);
        wait_drain();
        chk_fr("final_active", read_active(), model_active);
        chk("final_ready", bus.cfg_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
